// File: rtl/usb_ctrl_out_ep_buffer.sv
// ---------------------------------------------------------------------------
// usb_ctrl_out_ep_buffer
//   Single-buffered OUT/SETUP endpoint buffer for the control endpoint.
//   The buffer captures one data packet from the protocol engine and strips
//   the trailing CRC16 bytes. It runs DATA0/DATA1 toggle checking and decides
//   which packets are acknowledged. The consumer then reads the payload
//   through a req/grant/get handshake. Read data is registered, so it appears
//   one cycle after a counted get.
// ---------------------------------------------------------------------------
module usb_ctrl_out_ep_buffer #(
  parameter int MAX_PKT_SIZE = 32
) (
  input  logic       clk,
  input  logic       reset,
  // protocol engine side
  input  logic       rx_pkt_start,
  input  logic       rx_pkt_setup,
  input  logic       rx_pkt_data1,
  input  logic       rx_data_put,
  input  logic [7:0] rx_data,
  input  logic       rx_pkt_end,
  input  logic       rx_pkt_valid,
  output logic       rx_ready,
  output logic       rx_ack,
  output logic       rx_stall,
  // consumer side
  input  logic       out_ep_req,
  output logic       out_ep_grant,
  output logic       out_ep_data_avail,
  output logic       out_ep_setup,
  input  logic       out_ep_data_get,
  output logic [7:0] out_ep_data,
  input  logic       out_ep_stall,
  output logic       out_ep_acked
);

  // Storage holds a full payload plus the two CRC bytes. The CRC bytes are
  // written like payload bytes and simply never handed to the consumer.
  localparam int               BUF_SIZE   = MAX_PKT_SIZE + 2;
  // One extra code point so the write counter can sit at BUF_SIZE when full.
  localparam int               CNT_W      = $clog2(MAX_PKT_SIZE + 3);
  localparam logic [CNT_W-1:0] BUF_SIZE_C = CNT_W'(BUF_SIZE);
  localparam logic [CNT_W-1:0] CRC_LEN    = CNT_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [7:0]       r_buf [0:BUF_SIZE-1];
  logic [CNT_W-1:0] r_wr_cnt;
  logic             r_ovf;
  logic             r_is_setup;
  logic             r_toggle;      // expected data PID: 0 = DATA0, 1 = DATA1
  logic [CNT_W-1:0] r_length;      // payload length of the held packet
  logic [CNT_W-1:0] r_rd_ptr;
  logic             r_setup;       // held packet came from a SETUP token
  logic             r_ack;
  logic             r_acked;
  logic [7:0]       r_data;

  logic             w_grant;
  logic             w_avail;
  logic             w_get;
  logic             w_drop;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_rd_ptr_inc;
  logic             w_start_rx;
  logic             w_wr_en;
  logic             w_ovf_set;
  logic             w_accept;
  logic             w_dup;

  // Consumer handshake qualifiers. A get only counts while a byte is left.
  assign w_grant      = out_ep_req && (r_state == ST_HOLD);
  assign w_avail      = (r_state == ST_HOLD) && (r_rd_ptr < r_length);
  assign w_get        = out_ep_data_get && w_grant && w_avail;
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

  // End-of-packet screening. A bad CRC, an overflow, or a packet too short
  // to hold its own CRC is dropped silently.
  assign w_drop = !rx_pkt_valid || r_ovf || (r_wr_cnt < CRC_LEN);
  assign w_len  = r_wr_cnt - CRC_LEN;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: every clocked assignment is non-blocking. All registers then
      // update together from the values that held before the edge.
      r_state <= w_state_next;
    end
  end

  // Next-state decode and the per-cycle datapath strobes.
  always_comb begin
    // NOTE: defaults come first so every path assigns every signal. An
    // incomplete assignment here would infer a latch.
    w_state_next = r_state;
    w_start_rx   = 1'b0;
    w_wr_en      = 1'b0;
    w_ovf_set    = 1'b0;
    w_accept     = 1'b0;
    w_dup        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (rx_pkt_start) begin
          w_start_rx   = 1'b1;
          w_state_next = ST_RECV;
        end
      end

      ST_RECV: begin
        if (rx_pkt_start) begin
          // A new start aborts the packet in flight. No ack is sent for it.
          w_start_rx   = 1'b1;
          w_state_next = ST_RECV;
        end else begin
          if (rx_data_put) begin
            if (r_wr_cnt < BUF_SIZE_C) begin
              w_wr_en = 1'b1;
            end else begin
              w_ovf_set = 1'b1;
            end
          end
          if (rx_pkt_end) begin
            if (w_drop) begin
              w_state_next = ST_IDLE;
            end else if (r_is_setup || (rx_pkt_data1 == r_toggle)) begin
              w_accept     = 1'b1;
              w_state_next = (w_len != '0) ? ST_HOLD : ST_IDLE;
            end else begin
              // Retransmission of a packet we already took: ACK it so the
              // host moves on, but keep none of the data.
              w_dup        = 1'b1;
              w_state_next = ST_IDLE;
            end
          end
        end
      end

      ST_HOLD: begin
        if (rx_pkt_start && rx_pkt_setup) begin
          // SETUP always wins. The unread data is abandoned.
          w_start_rx   = 1'b1;
          w_state_next = ST_RECV;
        end else if (w_get && (w_rd_ptr_inc == r_length)) begin
          w_state_next = ST_IDLE;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  // Packet bookkeeping: write counter, toggle, read pointer and the pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_cnt   <= '0;
      r_ovf      <= 1'b0;
      r_is_setup <= 1'b0;
      r_toggle   <= 1'b0;
      r_length   <= '0;
      r_rd_ptr   <= '0;
      r_setup    <= 1'b0;
      r_ack      <= 1'b0;
      r_acked    <= 1'b0;
      r_data     <= 8'h00;
    end else begin
      r_ack   <= w_accept || w_dup;
      r_acked <= w_accept;

      if (w_start_rx) begin
        r_wr_cnt   <= '0;
        r_ovf      <= 1'b0;
        r_is_setup <= rx_pkt_setup;
      end else begin
        if (w_wr_en) begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
        if (w_ovf_set) begin
          r_ovf <= 1'b1;
        end
      end

      if (w_accept) begin
        r_length <= w_len;
        r_rd_ptr <= '0;
        r_setup  <= r_is_setup;
        // A SETUP resets the data stage to DATA1. A data packet advances it.
        r_toggle <= r_is_setup ? 1'b1 : ~r_toggle;
      end else if (w_get) begin
        r_data   <= r_buf[r_rd_ptr];
        r_rd_ptr <= w_rd_ptr_inc;
      end
    end
  end

  // Packet storage.
  always_ff @(posedge clk) begin
    // NOTE: the byte array is not reset. Nothing reads it before it is
    // written, and leaving out the reset lets it map onto plain RAM.
    if (w_wr_en) begin
      r_buf[r_wr_cnt] <= rx_data;
    end
  end

  assign rx_ready          = (r_state == ST_IDLE);
  assign rx_ack            = r_ack;
  assign rx_stall          = out_ep_stall;
  assign out_ep_grant      = w_grant;
  assign out_ep_data_avail = w_avail;
  assign out_ep_setup      = r_setup;
  assign out_ep_data       = r_data;
  assign out_ep_acked      = r_acked;

endmodule

// File: tb/tb_usb_ctrl_out_ep_buffer.sv
// ---------------------------------------------------------------------------
// tb_usb_ctrl_out_ep_buffer
//   Scenario bench for the control OUT endpoint buffer. Each accepted packet
//   pushes its payload bytes to a scoreboard queue. Each consumer get pops
//   one byte and compares it with the registered read data.
// ---------------------------------------------------------------------------
module tb_usb_ctrl_out_ep_buffer;

  localparam int MAX_PKT_SIZE = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_pkt_start, rx_pkt_setup, rx_pkt_data1, rx_data_put;
  logic [7:0] rx_data;
  logic       rx_pkt_end, rx_pkt_valid;
  logic       rx_ready, rx_ack, rx_stall;
  logic       out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup;
  logic       out_ep_data_get;
  logic [7:0] out_ep_data;
  logic       out_ep_stall, out_ep_acked;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx [0:63];
  bit         ready_seen;

  usb_ctrl_out_ep_buffer #(.MAX_PKT_SIZE(MAX_PKT_SIZE)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_pkt_start     (rx_pkt_start),
    .rx_pkt_setup     (rx_pkt_setup),
    .rx_pkt_data1     (rx_pkt_data1),
    .rx_data_put      (rx_data_put),
    .rx_data          (rx_data),
    .rx_pkt_end       (rx_pkt_end),
    .rx_pkt_valid     (rx_pkt_valid),
    .rx_ready         (rx_ready),
    .rx_ack           (rx_ack),
    .rx_stall         (rx_stall),
    .out_ep_req       (out_ep_req),
    .out_ep_grant     (out_ep_grant),
    .out_ep_data_avail(out_ep_data_avail),
    .out_ep_setup     (out_ep_setup),
    .out_ep_data_get  (out_ep_data_get),
    .out_ep_data      (out_ep_data),
    .out_ep_stall     (out_ep_stall),
    .out_ep_acked     (out_ep_acked)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one packet: start, n bytes from tx[], then end. Returns 1 unit
  // after the edge that sampled rx_pkt_end, when the ack pulse is visible.
  task automatic send_pkt(input logic setup, input logic data1,
                          input logic valid, input int n);
    ready_seen   = 1'b0;
    rx_pkt_start = 1'b1;
    rx_pkt_setup = setup;
    cyc();
    if (rx_ready) ready_seen = 1'b1;
    rx_pkt_start = 1'b0;
    rx_pkt_setup = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_data_put = 1'b1;
      rx_data     = tx[i];
      cyc();
      if (rx_ready) ready_seen = 1'b1;
    end
    rx_data_put  = 1'b0;
    rx_pkt_end   = 1'b1;
    rx_pkt_valid = valid;
    rx_pkt_data1 = data1;
    cyc();
    rx_pkt_end   = 1'b0;
    rx_pkt_valid = 1'b0;
    rx_pkt_data1 = 1'b0;
  endtask

  // Pops n bytes through the consumer port and scores each one.
  task automatic read_bytes(input int n, input string tag);
    logic [7:0] exp;
    out_ep_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      out_ep_data_get = 1'b1;
      cyc();
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s_byte%0d: got %h, scoreboard empty", tag, i, out_ep_data);
      end else begin
        exp = exp_q.pop_front();
        if (out_ep_data !== exp)
          $display("FAIL %s_byte%0d: got %h want %h", tag, i, out_ep_data, exp);
        else pass_cnt++;
      end
    end
    out_ep_data_get = 1'b0;
    out_ep_req      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset      = 1'b0;
    out_ep_req = 1'b1;
    #1;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", rx_ready); else pass_cnt++;
    total_cnt++; if (rx_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", rx_ack); else pass_cnt++;
    total_cnt++; if (out_ep_acked !== 1'b0) $display("FAIL rst_acked: got %b want 0", out_ep_acked); else pass_cnt++;
    total_cnt++; if (out_ep_grant !== 1'b0) $display("FAIL rst_grant: got %b want 0", out_ep_grant); else pass_cnt++;
    total_cnt++; if (out_ep_data_avail !== 1'b0) $display("FAIL rst_avail: got %b want 0", out_ep_data_avail); else pass_cnt++;
    total_cnt++; if (out_ep_setup !== 1'b0) $display("FAIL rst_setup: got %b want 0", out_ep_setup); else pass_cnt++;
    total_cnt++; if (out_ep_data !== 8'h00) $display("FAIL rst_data: got %h want 00", out_ep_data); else pass_cnt++;
    total_cnt++; if (rx_stall !== 1'b0) $display("FAIL rst_stall0: got %b want 0", rx_stall); else pass_cnt++;
    out_ep_req   = 1'b0;
    out_ep_stall = 1'b1;
    #1;
    total_cnt++; if (rx_stall !== 1'b1) $display("FAIL stall_pass: got %b want 1", rx_stall); else pass_cnt++;
    out_ep_stall = 1'b0;
    cyc();
  endtask

  task automatic test_setup();
    logic [7:0] req [0:7];
    req = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00};
    for (int i = 0; i < 8; i++) begin
      tx[i] = req[i];
      exp_q.push_back(req[i]);
    end
    tx[8] = 8'hAB;
    tx[9] = 8'hCD;
    send_pkt(1'b1, 1'b0, 1'b1, 10);
    total_cnt++; if (rx_ack !== 1'b1) $display("FAIL setup_ack: got %b want 1", rx_ack); else pass_cnt++;
    total_cnt++; if (out_ep_acked !== 1'b1) $display("FAIL setup_acked: got %b want 1", out_ep_acked); else pass_cnt++;
    total_cnt++; if (out_ep_data_avail !== 1'b1) $display("FAIL setup_avail: got %b want 1", out_ep_data_avail); else pass_cnt++;
    total_cnt++; if (out_ep_setup !== 1'b1) $display("FAIL setup_flag: got %b want 1", out_ep_setup); else pass_cnt++;
    total_cnt++; if (rx_ready !== 1'b0) $display("FAIL setup_ready_hold: got %b want 0", rx_ready); else pass_cnt++;
    cyc();
    total_cnt++; if (rx_ack !== 1'b0) $display("FAIL setup_ack_width: got %b want 0", rx_ack); else pass_cnt++;
    total_cnt++; if (out_ep_acked !== 1'b0) $display("FAIL setup_acked_width: got %b want 0", out_ep_acked); else pass_cnt++;
    out_ep_req = 1'b1;
    #1;
    total_cnt++; if (out_ep_grant !== 1'b1) $display("FAIL setup_grant: got %b want 1", out_ep_grant); else pass_cnt++;
    read_bytes(8, "setup");
    total_cnt++; if (out_ep_data_avail !== 1'b0) $display("FAIL setup_avail_end: got %b want 0", out_ep_data_avail); else pass_cnt++;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL setup_ready_end: got %b want 1", rx_ready); else pass_cnt++;
    total_cnt++; if (out_ep_setup !== 1'b1) $display("FAIL setup_flag_stable: got %b want 1", out_ep_setup); else pass_cnt++;
  endtask

  // Status-stage ZLP as DATA1 right after SETUP; toggle expected to become 0.
  task automatic test_zlp();
    tx[0] = 8'h00;
    tx[1] = 8'h00;
    send_pkt(1'b0, 1'b1, 1'b1, 2);
    total_cnt++; if (rx_ack !== 1'b1) $display("FAIL zlp_ack: got %b want 1", rx_ack); else pass_cnt++;
    total_cnt++; if (out_ep_acked !== 1'b1) $display("FAIL zlp_acked: got %b want 1", out_ep_acked); else pass_cnt++;
    total_cnt++; if (out_ep_data_avail !== 1'b0) $display("FAIL zlp_avail: got %b want 0", out_ep_data_avail); else pass_cnt++;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL zlp_ready: got %b want 1", rx_ready); else pass_cnt++;
    total_cnt++; if (out_ep_setup !== 1'b0) $display("FAIL zlp_setup: got %b want 0", out_ep_setup); else pass_cnt++;
    cyc();
  endtask

  // DATA1 while DATA0 is expected: ack only. A following DATA0 is accepted.
  task automatic test_dup();
    tx[0] = 8'h55; tx[1] = 8'h12; tx[2] = 8'h34;
    send_pkt(1'b0, 1'b1, 1'b1, 3);
    total_cnt++; if (rx_ack !== 1'b1) $display("FAIL dup_ack: got %b want 1", rx_ack); else pass_cnt++;
    total_cnt++; if (out_ep_acked !== 1'b0) $display("FAIL dup_acked: got %b want 0", out_ep_acked); else pass_cnt++;
    total_cnt++; if (out_ep_data_avail !== 1'b0) $display("FAIL dup_avail: got %b want 0", out_ep_data_avail); else pass_cnt++;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL dup_ready: got %b want 1", rx_ready); else pass_cnt++;
    cyc();
    tx[0] = 8'h11;
    exp_q.push_back(8'h11);
    send_pkt(1'b0, 1'b0, 1'b1, 3);
    total_cnt++; if (out_ep_acked !== 1'b1) $display("FAIL dup_next_acked: got %b want 1", out_ep_acked); else pass_cnt++;
    total_cnt++; if (out_ep_data_avail !== 1'b1) $display("FAIL dup_next_avail: got %b want 1", out_ep_data_avail); else pass_cnt++;
    read_bytes(1, "dup_next");
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL dup_next_ready: got %b want 1", rx_ready); else pass_cnt++;
  endtask

  // Bad CRC, too short, overflow: all dropped silently. Expected toggle is 1.
  task automatic test_drop();
    for (int i = 0; i < 40; i++) tx[i] = 8'(i + 8'h40);
    send_pkt(1'b0, 1'b1, 1'b0, 4);
    total_cnt++; if (rx_ack !== 1'b0) $display("FAIL crc_ack: got %b want 0", rx_ack); else pass_cnt++;
    total_cnt++; if (out_ep_acked !== 1'b0) $display("FAIL crc_acked: got %b want 0", out_ep_acked); else pass_cnt++;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL crc_ready: got %b want 1", rx_ready); else pass_cnt++;
    cyc();
    total_cnt++; if (rx_ack !== 1'b0) $display("FAIL crc_ack_late: got %b want 0", rx_ack); else pass_cnt++;
    send_pkt(1'b0, 1'b1, 1'b1, 1);
    total_cnt++; if (rx_ack !== 1'b0) $display("FAIL short_ack: got %b want 0", rx_ack); else pass_cnt++;
    cyc();
    send_pkt(1'b0, 1'b1, 1'b1, MAX_PKT_SIZE + 3);
    total_cnt++; if (rx_ack !== 1'b0) $display("FAIL ovf_ack: got %b want 0", rx_ack); else pass_cnt++;
    total_cnt++; if (out_ep_acked !== 1'b0) $display("FAIL ovf_acked: got %b want 0", out_ep_acked); else pass_cnt++;
    total_cnt++; if (out_ep_data_avail !== 1'b0) $display("FAIL ovf_avail: got %b want 0", out_ep_data_avail); else pass_cnt++;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL ovf_ready: got %b want 1", rx_ready); else pass_cnt++;
    cyc();
    // Drops left the toggle alone, so DATA1 is still accepted.
    tx[0] = 8'h22;
    exp_q.push_back(8'h22);
    send_pkt(1'b0, 1'b1, 1'b1, 3);
    total_cnt++; if (out_ep_acked !== 1'b1) $display("FAIL drop_next_acked: got %b want 1", out_ep_acked); else pass_cnt++;
    read_bytes(1, "drop_next");
  endtask

  // Largest legal packet: MAX_PKT_SIZE payload bytes plus CRC, as DATA0.
  task automatic test_full_pkt();
    for (int i = 0; i < MAX_PKT_SIZE + 2; i++) begin
      tx[i] = 8'($urandom_range(0, 255));
      if (i < MAX_PKT_SIZE) exp_q.push_back(tx[i]);
    end
    send_pkt(1'b0, 1'b0, 1'b1, MAX_PKT_SIZE + 2);
    total_cnt++; if (out_ep_acked !== 1'b1) $display("FAIL full_acked: got %b want 1", out_ep_acked); else pass_cnt++;
    read_bytes(MAX_PKT_SIZE, "full");
    total_cnt++; if (out_ep_data_avail !== 1'b0) $display("FAIL full_avail_end: got %b want 0", out_ep_data_avail); else pass_cnt++;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL full_ready_end: got %b want 1", rx_ready); else pass_cnt++;
  endtask

  // A SETUP arriving in HOLD flushes unread bytes. An OUT start is ignored.
  task automatic test_flush();
    for (int i = 0; i < 10; i++) tx[i] = 8'(8'hA0 + i);
    for (int i = 0; i < 8; i++) exp_q.push_back(tx[i]);
    send_pkt(1'b1, 1'b0, 1'b1, 10);
    read_bytes(4, "flush_old");
    total_cnt++; if (out_ep_data_avail !== 1'b1) $display("FAIL flush_avail_mid: got %b want 1", out_ep_data_avail); else pass_cnt++;
    for (int i = 0; i < 4; i++) tx[i] = 8'(8'hC0 + i);
    send_pkt(1'b0, 1'b1, 1'b1, 4);
    total_cnt++; if (ready_seen !== 1'b0) $display("FAIL hold_ready_seen: got %b want 0", ready_seen); else pass_cnt++;
    total_cnt++; if (rx_ready !== 1'b0) $display("FAIL hold_ready: got %b want 0", rx_ready); else pass_cnt++;
    total_cnt++; if (rx_ack !== 1'b0) $display("FAIL hold_out_ack: got %b want 0", rx_ack); else pass_cnt++;
    total_cnt++; if (out_ep_data_avail !== 1'b1) $display("FAIL hold_out_avail: got %b want 1", out_ep_data_avail); else pass_cnt++;
    cyc();
    exp_q.delete();
    for (int i = 0; i < 10; i++) tx[i] = 8'(8'hB0 + i);
    for (int i = 0; i < 8; i++) exp_q.push_back(tx[i]);
    send_pkt(1'b1, 1'b0, 1'b1, 10);
    total_cnt++; if (out_ep_acked !== 1'b1) $display("FAIL flush_acked: got %b want 1", out_ep_acked); else pass_cnt++;
    total_cnt++; if (out_ep_setup !== 1'b1) $display("FAIL flush_setup: got %b want 1", out_ep_setup); else pass_cnt++;
    read_bytes(8, "flush_new");
    total_cnt++; if (out_ep_data_avail !== 1'b0) $display("FAIL flush_avail_end: got %b want 0", out_ep_data_avail); else pass_cnt++;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL flush_ready_end: got %b want 1", rx_ready); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    // Reset in the middle of receiving a packet.
    rx_pkt_start = 1'b1;
    cyc();
    rx_pkt_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_data_put = 1'b1;
      rx_data     = 8'(8'h70 + i);
      cyc();
    end
    rx_data_put = 1'b0;
    reset       = 1'b1;
    cyc();
    reset = 1'b0;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL rrecv_ready: got %b want 1", rx_ready); else pass_cnt++;
    total_cnt++; if (rx_ack !== 1'b0) $display("FAIL rrecv_ack: got %b want 0", rx_ack); else pass_cnt++;
    total_cnt++; if (out_ep_data_avail !== 1'b0) $display("FAIL rrecv_avail: got %b want 0", out_ep_data_avail); else pass_cnt++;
    cyc();
    // Reset while holding a SETUP with one byte already read.
    for (int i = 0; i < 10; i++) tx[i] = 8'(8'h90 + i);
    for (int i = 0; i < 8; i++) exp_q.push_back(tx[i]);
    send_pkt(1'b1, 1'b0, 1'b1, 10);
    read_bytes(1, "rhold_pre");
    exp_q.delete();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL rhold_ready: got %b want 1", rx_ready); else pass_cnt++;
    total_cnt++; if (rx_ack !== 1'b0) $display("FAIL rhold_ack: got %b want 0", rx_ack); else pass_cnt++;
    total_cnt++; if (out_ep_acked !== 1'b0) $display("FAIL rhold_acked: got %b want 0", out_ep_acked); else pass_cnt++;
    total_cnt++; if (out_ep_data_avail !== 1'b0) $display("FAIL rhold_avail: got %b want 0", out_ep_data_avail); else pass_cnt++;
    total_cnt++; if (out_ep_setup !== 1'b0) $display("FAIL rhold_setup: got %b want 0", out_ep_setup); else pass_cnt++;
    total_cnt++; if (out_ep_data !== 8'h00) $display("FAIL rhold_data: got %h want 00", out_ep_data); else pass_cnt++;
    cyc();
    // The toggle went back to DATA0, so a DATA0 packet must be accepted.
    tx[0] = 8'h33;
    exp_q.push_back(8'h33);
    send_pkt(1'b0, 1'b0, 1'b1, 3);
    total_cnt++; if (out_ep_acked !== 1'b1) $display("FAIL rhold_toggle_acked: got %b want 1", out_ep_acked); else pass_cnt++;
    read_bytes(1, "rhold_toggle");
  endtask

  initial begin
    reset           = 1'b1;
    rx_pkt_start    = 1'b0;
    rx_pkt_setup    = 1'b0;
    rx_pkt_data1    = 1'b0;
    rx_data_put     = 1'b0;
    rx_data         = 8'h00;
    rx_pkt_end      = 1'b0;
    rx_pkt_valid    = 1'b0;
    out_ep_req      = 1'b0;
    out_ep_data_get = 1'b0;
    out_ep_stall    = 1'b0;
    test_reset();
    test_setup();
    test_zlp();
    test_dup();
    test_drop();
    test_full_pkt();
    test_flush();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
